// File: rtl/uart_rx_cmd_parser.sv
// Command-frame parser behind a UART receiver: sync, address, data[, checksum] -> register write.
// Optional checksum byte enabled by defining UART_CMD_CHECKSUM_EN.
module uart_rx_cmd_parser #(
    parameter int          g_System_Clk    = 100_000_000,
    parameter int          g_Baud_Rate     = 9600,
    parameter int          g_Timeout_Bytes = 4,
    parameter logic [7:0]  g_Sync_Byte     = 8'hA5
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Wr_En,
    output logic [2:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Busy,
    output logic       o_Err_Addr,
    output logic       o_Err_Chk,
    output logic       o_Err_Timeout,
    output logic [7:0] o_Frame_Cnt
);

    localparam logic [31:0] c_Timeout =
        32'(g_Timeout_Bytes * 10 * (g_System_Clk / g_Baud_Rate) - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, CHK, WRITE} state_t;

    state_t      state_reg;
    logic        dv_prev_reg;
    logic [7:0]  addr_reg;
    logic [31:0] tmo_cnt_reg;
    logic        wr_en_reg;
    logic [2:0]  wr_addr_reg;
    logic [7:0]  wr_data_reg;
    logic        busy_reg;
    logic        err_addr_reg;
    logic        err_to_reg;
    logic [7:0]  frame_cnt_reg;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]  data_reg;
    logic        err_chk_reg;
`endif

    logic accept;
    logic tmo_hit;
    logic addr_bad;

    // Level-type DV from the receiver: only its rising edge marks a new byte.
    assign accept   = i_RX_DV && !dv_prev_reg;
    assign tmo_hit  = (tmo_cnt_reg == c_Timeout);
    assign addr_bad = (addr_reg[7:3] != 5'd0);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg     <= IDLE;
            dv_prev_reg   <= 1'b1;
            addr_reg      <= 8'd0;
            tmo_cnt_reg   <= 32'd0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= 3'd0;
            wr_data_reg   <= 8'd0;
            busy_reg      <= 1'b0;
            err_addr_reg  <= 1'b0;
            err_to_reg    <= 1'b0;
            frame_cnt_reg <= 8'd0;
`ifdef UART_CMD_CHECKSUM_EN
            data_reg      <= 8'd0;
            err_chk_reg   <= 1'b0;
`endif
        end else begin
            dv_prev_reg  <= i_RX_DV;
            wr_en_reg    <= 1'b0;
            err_addr_reg <= 1'b0;
            err_to_reg   <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            err_chk_reg  <= 1'b0;
`endif
            if (accept || state_reg == IDLE || state_reg == WRITE)
                tmo_cnt_reg <= 32'd0;
            else
                tmo_cnt_reg <= tmo_cnt_reg + 32'd1;

            case (state_reg)
                IDLE: begin
                    if (accept && i_RX_Byte == g_Sync_Byte) begin
                        state_reg <= ADDR;
                        busy_reg  <= 1'b1;
                    end
                end
                ADDR: begin
                    if (accept) begin
                        addr_reg  <= i_RX_Byte;
                        state_reg <= DATA;
                    end else if (tmo_hit) begin
                        err_to_reg <= 1'b1;
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                    end
                end
                DATA: begin
                    if (accept) begin
`ifdef UART_CMD_CHECKSUM_EN
                        data_reg  <= i_RX_Byte;
                        state_reg <= CHK;
`else
                        if (addr_bad) begin
                            err_addr_reg <= 1'b1;
                            state_reg    <= IDLE;
                            busy_reg     <= 1'b0;
                        end else begin
                            state_reg     <= WRITE;
                            wr_en_reg     <= 1'b1;
                            wr_addr_reg   <= addr_reg[2:0];
                            wr_data_reg   <= i_RX_Byte;
                            frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        end
`endif
                    end else if (tmo_hit) begin
                        err_to_reg <= 1'b1;
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        // Address error takes priority so one frame never flags both.
                        if (addr_bad) begin
                            err_addr_reg <= 1'b1;
                            state_reg    <= IDLE;
                            busy_reg     <= 1'b0;
                        end else if (i_RX_Byte != addr_reg + data_reg) begin
                            err_chk_reg <= 1'b1;
                            state_reg   <= IDLE;
                            busy_reg    <= 1'b0;
                        end else begin
                            state_reg     <= WRITE;
                            wr_en_reg     <= 1'b1;
                            wr_addr_reg   <= addr_reg[2:0];
                            wr_data_reg   <= data_reg;
                            frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        end
                    end else if (tmo_hit) begin
                        err_to_reg <= 1'b1;
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                    end
                end
`endif
                WRITE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Wr_En       = wr_en_reg;
    assign o_Wr_Addr     = wr_addr_reg;
    assign o_Wr_Data     = wr_data_reg;
    assign o_Busy        = busy_reg;
    assign o_Err_Addr    = err_addr_reg;
    assign o_Err_Timeout = err_to_reg;
    assign o_Frame_Cnt   = frame_cnt_reg;
`ifdef UART_CMD_CHECKSUM_EN
    assign o_Err_Chk     = err_chk_reg;
`else
    assign o_Err_Chk     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Directed bench for uart_rx_cmd_parser; frame length follows UART_CMD_CHECKSUM_EN.
module tb_uart_rx_cmd_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       err_addr;
    logic       err_chk;
    logic       err_to;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    // Pulse counters sampled on rising edges (value held over the previous cycle).
    int         wr_cnt = 0, ea_cnt = 0, ec_cnt = 0, et_cnt = 0;
    logic [2:0] last_addr = 3'd0;
    logic [7:0] last_data = 8'd0;
    int         s_wr, s_ea, s_ec, s_et;

    uart_rx_cmd_parser #(
        .g_System_Clk   (10_000_000),
        .g_Baud_Rate    (1_000_000),
        .g_Timeout_Bytes(4),
        .g_Sync_Byte    (8'hA5)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_RX_DV      (rx_dv),
        .i_RX_Byte    (rx_byte),
        .o_Wr_En      (wr_en),
        .o_Wr_Addr    (wr_addr),
        .o_Wr_Data    (wr_data),
        .o_Busy       (busy),
        .o_Err_Addr   (err_addr),
        .o_Err_Chk    (err_chk),
        .o_Err_Timeout(err_to),
        .o_Frame_Cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= wr_addr;
            last_data <= wr_data;
        end
        if (err_addr) ea_cnt <= ea_cnt + 1;
        if (err_chk)  ec_cnt <= ec_cnt + 1;
        if (err_to)   et_cnt <= et_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic snap();
        s_wr = wr_cnt; s_ea = ea_cnt; s_ec = ec_cnt; s_et = et_cnt;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi);
        @(negedge clk);
        rx_dv = 1'b1; rx_byte = b;
        repeat (hi) @(negedge clk);
        rx_dv = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] c, input int hi);
        send_byte(8'hA5, hi);
        send_byte(a, hi);
        send_byte(d, hi);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(c, hi);
`endif
    endtask

    initial begin
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_wr_en",  {31'd0, wr_en},    32'd0);
        check("rst_addr",   {29'd0, wr_addr},  32'd0);
        check("rst_data",   {24'd0, wr_data},  32'd0);
        check("rst_busy",   {31'd0, busy},     32'd0);
        check("rst_errs",   {29'd0, err_addr, err_chk, err_to}, 32'd0);
        check("rst_fcnt",   {24'd0, frame_cnt}, 32'd0);
        rst = 1'b0;

        // Good frame, DV held 100 cycles per byte
        snap();
        send_byte(8'hA5, 100);
        check("busy_mid",   {31'd0, busy}, 32'd1);
        send_byte(8'h03, 100);
        send_byte(8'h5C, 100);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h5F, 100);
`endif
        check("good_wr",    wr_cnt - s_wr, 32'd1);
        check("good_addr",  {29'd0, last_addr}, 32'd3);
        check("good_data",  {24'd0, last_data}, 32'h5C);
        check("good_fcnt",  {24'd0, frame_cnt}, 32'd1);
        check("good_idle",  {31'd0, busy}, 32'd0);

`ifdef UART_CMD_CHECKSUM_EN
        snap();
        send_frame(8'h02, 8'h10, 8'h00, 3);
        check("badchk_err", ec_cnt - s_ec, 32'd1);
        check("badchk_wr",  wr_cnt - s_wr, 32'd0);
`endif
        snap();
        send_frame(8'h01, 8'h01, 8'h02, 3);
        check("f2_wr",      wr_cnt - s_wr, 32'd1);
        check("f2_addr",    {29'd0, last_addr}, 32'd1);
        check("f2_data",    {24'd0, last_data}, 32'd1);

        // Bad address: only the address error may fire
        snap();
        send_frame(8'h08, 8'h00, 8'h08, 3);
        check("badaddr_ea", ea_cnt - s_ea, 32'd1);
        check("badaddr_ec", ec_cnt - s_ec, 32'd0);
        check("badaddr_wr", wr_cnt - s_wr, 32'd0);

        snap();
        send_byte(8'h00, 5);
        check("garb_busy",  {31'd0, busy}, 32'd0);
        check("garb_wr",    wr_cnt - s_wr, 32'd0);

        // Sync value as data is ordinary data
        send_frame(8'h02, 8'hA5, 8'hA7, 3);
        check("syncdat_a",  {29'd0, last_addr}, 32'd2);
        check("syncdat_d",  {24'd0, last_data}, 32'hA5);
        check("syncdat_fc", {24'd0, frame_cnt}, 32'd3);

        // Timeout: 4 bytes * 10 bits * 10 clk/bit = 400 cycles after last accept
        snap();
        send_byte(8'hA5, 1);
        @(negedge clk); rx_dv = 1'b1; rx_byte = 8'h01;
        @(posedge clk);
        @(negedge clk); rx_dv = 1'b0;
        repeat (399) @(posedge clk);
        #1;
        check("to_399",     {31'd0, err_to}, 32'd0);
        check("to_399_busy",{31'd0, busy},   32'd1);
        @(posedge clk); #1;
        check("to_400",     {31'd0, err_to}, 32'd1);
        check("to_400_busy",{31'd0, busy},   32'd0);
        @(negedge clk);
        @(negedge clk);
        check("to_count",   et_cnt - s_et, 32'd1);

        // Accept on the expiry cycle wins
        snap();
        send_byte(8'hA5, 1);
        @(negedge clk); rx_dv = 1'b1; rx_byte = 8'h01;
        @(posedge clk);
        @(negedge clk); rx_dv = 1'b0;
        repeat (399) @(posedge clk);
        @(negedge clk); rx_dv = 1'b1; rx_byte = 8'h02;
        @(posedge clk); #1;
        check("race_noerr", {31'd0, err_to}, 32'd0);
        check("race_busy",  {31'd0, busy},   32'd1);
        @(negedge clk); rx_dv = 1'b0;
        @(negedge clk);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h03, 1);
`endif
        check("race_et",    et_cnt - s_et, 32'd0);
        check("race_wr",    wr_cnt - s_wr, 32'd1);
        check("race_data",  {24'd0, last_data}, 32'd2);

        // Reset mid-frame with a sync-valued byte held on DV across reset
        send_byte(8'hA5, 3);
        @(negedge clk); rx_dv = 1'b1; rx_byte = 8'hA5;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mrst_busy",  {31'd0, busy},      32'd0);
        check("mrst_fcnt",  {24'd0, frame_cnt}, 32'd0);
        check("mrst_data",  {24'd0, wr_data},   32'd0);
        repeat (5) @(negedge clk);
        check("held_noacc", {31'd0, busy}, 32'd0);
        rx_dv = 1'b0;
        @(negedge clk);
        snap();
        send_frame(8'h05, 8'h33, 8'h38, 3);
        check("post_addr",  {29'd0, last_addr}, 32'd5);
        check("post_data",  {24'd0, last_data}, 32'h33);
        check("post_fcnt",  {24'd0, frame_cnt}, 32'd1);

        // Frame counter wrap
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        snap();
        for (int i = 0; i < 255; i++) send_frame(8'h04, 8'(i), 8'(i + 4), 1);
        check("wrap_255",   {24'd0, frame_cnt}, 32'd255);
        send_frame(8'h04, 8'h11, 8'h15, 1);
        check("wrap_0",     {24'd0, frame_cnt}, 32'd0);
        check("wrap_wr",    wr_cnt - s_wr, 32'd256);
        check("wrap_errs",  (ea_cnt - s_ea) + (ec_cnt - s_ec) + (et_cnt - s_et), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
